// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock, start/busy/done handshake.
// Define SHIFT_ADD_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier #(
    parameter int A_WIDTH = 3,
    parameter int B_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic                       busy,
    output logic                       done,
    output logic [A_WIDTH+B_WIDTH-1:0] product
);

    localparam int P_W   = A_WIDTH + B_WIDTH;
    localparam int CNT_W = $clog2(B_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [P_W-1:0]     mcand_q, mcand_d;
    logic [P_W-1:0]     acc_q, acc_d;
    logic [P_W-1:0]     product_q, product_d;
    logic [B_WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               last_iter;
    logic [P_W-1:0]     acc_sum;
    logic [B_WIDTH-1:0] mplier_shr;

    // Partial-product accumulate; the accumulator is full width so the sum never wraps.
    function automatic logic [P_W-1:0] add_partial(
        input logic [P_W-1:0] acc,
        input logic [P_W-1:0] mcand,
        input logic           mbit
    );
        return mbit ? (acc + mcand) : acc;
    endfunction

    assign accept     = start && (state_q != S_RUN);
    assign acc_sum    = add_partial(acc_q, mcand_q, mplier_q[0]);
    assign mplier_shr = mplier_q >> 1;

`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CNT_LAST) || (mplier_shr == '0);
`else
    assign last_iter = (cnt_q == CNT_LAST);
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    mcand_d  = {{B_WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q + CNT_W'(1);
                // The finishing edge publishes this edge's sum directly.
                if (last_iter) begin
                    product_d = acc_sum;
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: driver pushes expected results, a negedge monitor checks them.
module tb_shift_add_multiplier;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [6:0] product;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    shift_add_multiplier u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    shift_add_multiplier #(.A_WIDTH(8), .B_WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    typedef struct {
        int prod;
        int done_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_prod = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycles from accept edge to finish edge, straight from the latency rules.
    function automatic int lat_of(input int bv, input int bw);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        int p;
        p = -1;
        for (int i = 0; i < bw; i++)
            if (((bv >> i) & 1) == 1) p = i;
        return (p < 0) ? 1 : p + 1;
`else
        return bw;
`endif
    endfunction

    // Monitor: expected busy/done/product follow from the oldest outstanding entry.
    always @(negedge clk) begin
        logic exp_busy;
        logic exp_done;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (q.size() > 0) begin
            if (cyc < q[0].done_cyc) exp_busy = 1'b1;
            else if (cyc == q[0].done_cyc) exp_done = 1'b1;
        end
        if (exp_done) begin
            exp_prod = q[0].prod;
            void'(q.pop_front());
        end
        chk("busy", longint'(busy), longint'(exp_busy));
        chk("done", longint'(done), longint'(exp_done));
        chk("product", longint'(product), longint'(exp_prod));
    end

    // Called just after a rising edge; the DUT accepts on the next edge.
    task automatic issue(input int ai, input int bi, output int lat_o);
        a     = 3'(ai);
        b     = 4'(bi);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat_o = lat_of(bi, 4);
        q.push_back('{prod: ai * bi, done_cyc: cyc + lat_o});
    endtask

    // Runs one operation and returns in its DONE cycle plus gap cycles; poke pulses an ignored start.
    task automatic run_op(input int ai, input int bi, input int gap, input bit poke, input int pk);
        int lat;
        issue(ai, bi, lat);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            if (poke && k == pk && k < lat) begin
                start = 1'b1;
                a     = 3'($urandom);
                b     = 4'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic op8(input int ai, input int bi);
        int lat;
        a8     = 8'(ai);
        b8     = 8'(bi);
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat = lat_of(bi, 8);
        repeat (lat - 1) @(posedge clk);
        #1;
        chk("w8_busy_last_run", longint'(busy8), 1);
        chk("w8_done_early", longint'(done8), 0);
        @(posedge clk);
        #1;
        chk("w8_done", longint'(done8), 1);
        chk("w8_busy_done", longint'(busy8), 0);
        chk("w8_product", longint'(product8), longint'(ai * bi));
        @(posedge clk);
        #1;
        chk("w8_done_pulse", longint'(done8), 0);
        chk("w8_product_hold", longint'(product8), longint'(ai * bi));
    endtask

    initial begin
        int lat;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end

        run_op(5, 12, 2, 1'b0, 0);
        run_op(4, 1, 2, 1'b0, 0);
        run_op(7, 15, 1, 1'b0, 0);

        // Start during RUN must be ignored; start in the DONE cycle must be taken.
        run_op(3, 3, 0, 1'b1, 1);
        run_op(1, 1, 3, 1'b0, 0);

        for (int ai = 0; ai < 8; ai++)
            for (int bi = 0; bi < 16; bi++)
                run_op(ai, bi, (ai + bi) % 2, 1'b0, 0);

        for (int n = 0; n < 250; n++)
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)), 1'($urandom), int'($urandom_range(1, 3)));

        // Reset in the second RUN cycle discards the operation and clears the result.
        issue(3, 3, lat);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        exp_prod = 0;
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_product", longint'(product), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(6, 13, 2, 1'b0, 0);

        op8(255, 255);
        op8(4, 1);
        op8(255, 1);
        op8(200, 0);

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("scoreboard_drained", longint'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Parametrised sequential unsigned multiplier that computes `a * b` by shift-and-add, one multiplier bit per clock. It is the clocked, width-generic successor to the team's fixed 3x4 combinational array multiplier. It has a start/busy/done handshake and a registered result that stays stable while the next operation runs. It is meant for datapaths where multiplier area matters more than latency.

## Interface
Parameters:
- `A_WIDTH`, default 3: multiplicand width. Must be 1 or more.
- `B_WIDTH`, default 4: multiplier width, and the number of iterations. Must be 2 or more.

Ports:
- `clk`, input, 1: the single clock. Every register updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request a new multiplication. Sampled on the rising edge of `clk`.
- `a`, input, `A_WIDTH`: multiplicand. Captured on the accept edge.
- `b`, input, `B_WIDTH`: multiplier. Captured on the accept edge.
- `busy`, output, 1: high while an operation is in progress.
- `done`, output, 1: one-cycle pulse marking that `product` has just been updated.
- `product`, output, `A_WIDTH+B_WIDTH`: registered result, unsigned, full width.

## Operation
- States:
  - IDLE: after reset.
  - RUN: iterating.
  - DONE: lasts one cycle.
- Accept rule: `start=1` at a rising edge while the state is IDLE or DONE.
  - Latch `a` into the multiplicand register, zero-extended to `A_WIDTH+B_WIDTH`.
  - Latch `b` into the multiplier shift register.
  - Clear the accumulator and the iteration counter.
  - Go to RUN.
- `start` while in RUN is ignored. The current operation is unaffected.
- Each RUN edge:
  - If the multiplier LSB is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
- Finish condition: the counter reaches `B_WIDTH`, or the early-exit condition is met (see Configuration).
  - On that same edge, load `product` with the final accumulator value (including this edge's add).
  - Go to DONE.
- DONE:
  - `done=1` and `busy=0`.
  - If `start=1`, it is accepted, giving back-to-back operation. Otherwise the block goes to IDLE.
- Arithmetic:
  - Unsigned only. The accumulator is `A_WIDTH+B_WIDTH` bits and cannot overflow.
  - Maximum result is (2^A_WIDTH−1)(2^B_WIDTH−1).
- `product` holds its value through IDLE and through the entire next operation. It changes only on a finish edge or on reset.
- Reset (asserted at any time, including mid-RUN):
  - State goes to IDLE immediately.
  - `busy=0`, `done=0`, `product=0`, and all internal registers are cleared.
  - Any operation in progress is discarded.

## Timing
- Reset values: `busy=0`, `done=0`, `product=0`.
- Accept at edge E0: `busy=1` from E0 until the finish edge.
- Fixed latency (macro undefined):
  - `busy` is high for exactly `B_WIDTH` cycles.
  - `done=1` and the new `product` are visible after edge E0+`B_WIDTH`.
- `done` is high for exactly 1 cycle unless another operation finishes in the very next cycle.
- Back-to-back throughput: one result every `B_WIDTH`+1 cycles.
- `a` and `b` only need to be valid on the accept edge.
- Deassertion of `rst_n` is assumed synchronous to `clk` at system level. The block adds no synchroniser.

## Configuration
- Macro `SHIFT_ADD_MULT_EARLY_EXIT_EN`.
- When defined: finish on the first RUN edge after which the shifted multiplier register is all zero.
  - Latency = max(1, position of the highest set bit of `b` + 1) cycles.
  - `b=0` finishes after 1 cycle with `product=0`.
- When undefined: latency is always `B_WIDTH` cycles, regardless of `b`.
- Results are identical in both builds. Only `busy` and `done` timing differ.

## Test plan
All scenarios use default parameters unless stated.
- Reset, then idle: hold `start=0` for 10 cycles -> `busy=0`, `done=0`, `product=0`.
- Basic operation: `a=5`, `b=12`, 1-cycle `start` -> `done` 4 cycles after the accept edge with `product=60` (7'b0111100). Then `a=4`, `b=1` -> `product=4`.
- Maximum operands: `a=7`, `b=15` -> `product=105`. Also sweep all 128 operand pairs against a reference model.
- Start during busy: pulse `start` with `a=1`, `b=1` two cycles into an operation with `a=3`, `b=3` -> ignored; `product=9`. Follow with `start` in the DONE cycle -> accepted; next result `1`.
- Reset mid-operation: assert `rst_n=0` on the second RUN cycle -> `busy`, `done`, `product` all 0 immediately. A new operation after release completes normally.
- Early exit: `a=4`, `b=1`.
  - With `SHIFT_ADD_MULT_EARLY_EXIT_EN`: `done` after 1 cycle.
  - Without it: `done` after 4 cycles.
  - Both builds: `product=4`.
  - Repeat with `A_WIDTH=8`, `B_WIDTH=8`, `a=255`, `b=255` -> `product=65025`.
